// File: rtl/core_clock_pkg.sv
// Shared types for the core clock controller: sleep/wake state encoding.
package core_clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/core_clock_idle_ctr.sv
// Per-domain saturating idle counter; gate is high once IDLE_CYCLES consecutive
// idle cycles have been seen while the controller is in RUN.
module core_clock_idle_ctr #(
  parameter int IDLE_CYCLES = 8
) (
  input  logic f_clk,
  input  logic g_reset,
  input  logic run,
  input  logic idle,
  output logic gate
);

  localparam int CW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge f_clk or posedge g_reset) begin
    if (g_reset)                cnt <= '0;
    else if (!run || !idle)     cnt <= '0;
    else if (cnt != IDLE_MAX)   cnt <= cnt + 1'b1;
  end

  assign gate = (cnt == IDLE_MAX);

endmodule

// File: rtl/core_clock_ctrl.sv
// Core clock controller: RUN/DRAIN/SLEEP/WAKE sequencing of per-domain clock requests.
// Optional per-domain idle auto-gating in RUN when CORE_CLOCK_AUTO_GATE_EN is defined.
module core_clock_ctrl
  import core_clock_pkg::*;
#(
  parameter int N_DOMAINS   = 3,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8
) (
  input  logic                 f_clk,
  input  logic                 g_reset,
  input  logic                 wfi_req,
  input  logic                 wakeup,
  input  logic [N_DOMAINS-1:0] dom_busy,
  input  logic [N_DOMAINS-1:0] dom_req,
  output logic [N_DOMAINS-1:0] clk_req,
  output logic                 sleeping
);

  if (WAKE_CYCLES < 1) begin : g_bad_wake
    $error("core_clock_ctrl: WAKE_CYCLES must be >= 1");
  end
  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("core_clock_ctrl: IDLE_CYCLES must be >= 1");
  end

  localparam int WCW = $clog2(WAKE_CYCLES + 1);
  localparam logic [WCW-1:0] WAKE_LOAD = WCW'(WAKE_CYCLES - 1);

  ctrl_state_e            state, nxt;
  logic [WCW-1:0]         wake_cnt, wake_nxt;
  logic [N_DOMAINS-1:0]   clk_req_q, clk_nxt;

  always_ff @(posedge f_clk or posedge g_reset) begin
    if (g_reset) begin
      state     <= RUN;
      wake_cnt  <= '0;
      clk_req_q <= '1;
      sleeping  <= 1'b0;
    end else begin
      state     <= nxt;
      wake_cnt  <= wake_nxt;
      clk_req_q <= clk_nxt;
      sleeping  <= (nxt == SLEEP);
    end
  end

  always_comb begin
    nxt      = state;
    wake_nxt = wake_cnt;
    unique case (state)
      RUN:   if (wfi_req && !wakeup) nxt = DRAIN;
      DRAIN: begin
        if (wakeup || !wfi_req)     nxt = RUN;
        else if (dom_busy == '0)    nxt = SLEEP;
      end
      SLEEP: begin
        // wfi_req dropping alone is ignored here; only a wake event leaves sleep
        if (wakeup) begin
          nxt      = WAKE;
          wake_nxt = WAKE_LOAD;
        end
      end
      WAKE: begin
        if (wake_cnt == '0) nxt = RUN;
        else                wake_nxt = wake_cnt - 1'b1;
      end
      default: nxt = RUN;
    endcase
    clk_nxt = (nxt == SLEEP) ? dom_req : '1;
  end

`ifdef CORE_CLOCK_AUTO_GATE_EN
  logic [N_DOMAINS-1:0] gate;
  logic                 in_run;

  assign in_run = (state == RUN);

  for (genvar i = 0; i < N_DOMAINS; i++) begin : g_idle
    core_clock_idle_ctr #(.IDLE_CYCLES(IDLE_CYCLES)) u_ctr (
      .f_clk   (f_clk),
      .g_reset (g_reset),
      .run     (in_run),
      .idle    (!dom_busy[i] && !dom_req[i]),
      .gate    (gate[i])
    );
  end

  // New activity overrides a gated domain in the same cycle
  assign clk_req = clk_req_q & ~(gate & ~(dom_busy | dom_req) & {N_DOMAINS{in_run}});
`else
  assign clk_req = clk_req_q;
`endif

endmodule

// File: tb/tb_core_clock_ctrl.sv
// Scoreboard bench for core_clock_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_core_clock_ctrl;

  logic       f_clk = 1'b0;
  logic       g_reset, wfi_req, wakeup;
  logic [2:0] dom_busy, dom_req, clk_req;
  logic       sleeping;

`ifdef CORE_CLOCK_AUTO_GATE_EN
  localparam bit AG = 1'b1;
`else
  localparam bit AG = 1'b0;
`endif

  always #5 f_clk = ~f_clk;

  core_clock_ctrl #(.N_DOMAINS(3), .WAKE_CYCLES(2), .IDLE_CYCLES(8)) dut (
    .f_clk    (f_clk),
    .g_reset  (g_reset),
    .wfi_req  (wfi_req),
    .wakeup   (wakeup),
    .dom_busy (dom_busy),
    .dom_req  (dom_req),
    .clk_req  (clk_req),
    .sleeping (sleeping)
  );

  typedef struct {
    logic [2:0] clk;
    logic       slp;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // One cycle: apply inputs just after the edge, expect outputs at the following negedge
  task automatic cyc(input logic r, input logic w, input logic k,
                     input logic [2:0] b, input logic [2:0] q,
                     input logic [2:0] ec, input logic es, input string nm);
    exp_t e;
    @(posedge f_clk); #1;
    g_reset = r; wfi_req = w; wakeup = k; dom_busy = b; dom_req = q;
    e.clk = ec; e.slp = es; e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge f_clk);
      if (sb.size() > 0) begin
        m_e = sb.pop_front();
        n_cmp++;
        if (clk_req !== m_e.clk || sleeping !== m_e.slp) begin
          n_bad++;
          $display("FAIL %s: got clk_req=%b sleeping=%b, want clk_req=%b sleeping=%b",
                   m_e.nm, clk_req, sleeping, m_e.clk, m_e.slp);
        end
      end
    end
  end

  initial begin
    g_reset = 1'b1; wfi_req = 1'b0; wakeup = 1'b0; dom_busy = '0; dom_req = '0;
    //   rst  wfi  wk   busy    req     exp_clk exp_slp
    cyc(1, 0, 0, 3'b000, 3'b000, 3'b111, 0, "reset");
    cyc(0, 0, 0, 3'b000, 3'b000, 3'b111, 0, "run_idle");
    // Drain held by a busy domain, then sleep
    cyc(0, 1, 0, 3'b010, 3'b000, 3'b111, 0, "run_wfi");
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 0, 3'b010, 3'b000, 3'b111, 0, "drain_busy");
    cyc(0, 1, 0, 3'b000, 3'b000, 3'b111, 0, "drain_last");
    cyc(0, 1, 0, 3'b000, 3'b000, 3'b000, 1, "sleep_entry");
    // wfi drop alone keeps sleep; dom_req passes through one cycle late
    cyc(0, 0, 0, 3'b000, 3'b100, 3'b000, 1, "sleep_wfi_drop");
    cyc(0, 0, 0, 3'b000, 3'b100, 3'b100, 1, "sleep_dom_req");
    cyc(0, 1, 1, 3'b000, 3'b100, 3'b100, 1, "sleep_wakeup");
    // WAKE dwell of exactly 2 cycles, revealed by re-sleep timing with wfi held
    cyc(0, 1, 0, 3'b000, 3'b000, 3'b111, 0, "wake1");
    cyc(0, 1, 0, 3'b000, 3'b000, 3'b111, 0, "wake2");
    cyc(0, 1, 0, 3'b000, 3'b000, 3'b111, 0, "run_after_wake");
    cyc(0, 1, 0, 3'b000, 3'b000, 3'b111, 0, "drain_after_wake");
    cyc(0, 1, 1, 3'b000, 3'b000, 3'b000, 1, "resleep");
    // Reset during WAKE, then confirm fresh RUN via the drain/sleep timing
    cyc(1, 0, 0, 3'b000, 3'b000, 3'b111, 0, "rst_mid_wake");
    cyc(0, 1, 0, 3'b000, 3'b000, 3'b111, 0, "run_after_rst");
    cyc(0, 1, 0, 3'b000, 3'b000, 3'b111, 0, "drain_after_rst");
    cyc(0, 0, 0, 3'b000, 3'b000, 3'b000, 1, "sleep_after_rst");
    cyc(1, 0, 0, 3'b000, 3'b000, 3'b111, 0, "rst_async_sleep");
    cyc(0, 0, 0, 3'b000, 3'b000, 3'b111, 0, "run_after_rst2");
    // wfi drop in DRAIN returns to RUN without sleeping
    cyc(0, 1, 0, 3'b001, 3'b000, 3'b111, 0, "run_wfi2");
    cyc(0, 0, 0, 3'b000, 3'b000, 3'b111, 0, "drain_wfi_drop");
    cyc(0, 0, 0, 3'b000, 3'b000, 3'b111, 0, "run_no_sleep");
    // wfi and wakeup together in RUN: stays RUN
    cyc(0, 1, 1, 3'b000, 3'b000, 3'b111, 0, "run_wfi_wake");
    cyc(0, 1, 0, 3'b000, 3'b000, 3'b111, 0, "run_kept");
    cyc(0, 1, 0, 3'b000, 3'b000, 3'b111, 0, "drain3");
    cyc(0, 1, 0, 3'b000, 3'b000, 3'b000, 1, "sleep3");
    cyc(0, 0, 1, 3'b000, 3'b000, 3'b000, 1, "sleep3_wake");
    // Domain 1 idle: two WAKE cycles then RUN; gating after 8 idle RUN cycles
    for (int j = 0; j < 12; j++)
      cyc(0, 0, 0, 3'b101, 3'b000, (AG && j >= 10) ? 3'b101 : 3'b111, 0, "idle_gate");
    cyc(0, 0, 0, 3'b111, 3'b000, 3'b111, 0, "busy_regrant");
    cyc(0, 0, 0, 3'b101, 3'b000, 3'b111, 0, "idle_ctr_cleared");
    repeat (3) @(negedge f_clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_queue: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_clock_ctrl.md
CORE_CLOCK_CTRL -- requirements
Module: core_clock_ctrl

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 3, number of gated clock domains controlled.
REQ-002 SHALL have parameter WAKE_CYCLES, default 2, number of cycles all clocks run before the controller returns to RUN.
REQ-003 SHALL have parameter IDLE_CYCLES, default 8, consecutive idle cycles before a domain auto-gates (used only with the macro in REQ-023).
REQ-004 SHALL have port f_clk, input, 1 bit: free-running, ungated clock; all state is clocked on its rising edge.
REQ-005 SHALL have port g_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port wfi_req, input, 1 bit: level request from the core to enter sleep.
REQ-007 SHALL have port wakeup, input, 1 bit: interrupt or debug wake pending.
REQ-008 SHALL have port dom_busy, input, N_DOMAINS bits: domain i has outstanding work.
REQ-009 SHALL have port dom_req, input, N_DOMAINS bits: domain i explicitly requests its clock.
REQ-010 SHALL have port clk_req, output, N_DOMAINS bits: clock request to the clock gate cell of domain i.
REQ-011 SHALL have port sleeping, output, 1 bit: high only while in SLEEP.

Function
REQ-012 SHALL implement the states RUN, DRAIN, SLEEP and WAKE, with a registered state and registered outputs.
REQ-013 RUN: clk_req all ones; wfi_req=1 and wakeup=0 -> DRAIN on the next edge.
REQ-014 DRAIN: clk_req all ones; priority wakeup=1 or wfi_req=0 -> RUN; else dom_busy==0 -> SLEEP; else stay.
REQ-015 SLEEP: clk_req[i] = dom_req[i] (registered, one-cycle latency); sleeping=1; wakeup=1 -> WAKE.
REQ-016 In SLEEP, a wfi_req deassertion without wakeup SHALL NOT exit sleep.
REQ-017 WAKE: clk_req all ones, sleeping=0; a down-counter loaded with WAKE_CYCLES-1 on entry; transition to RUN when it reaches 0; total WAKE dwell = WAKE_CYCLES cycles.
REQ-018 WAKE_CYCLES=1 SHALL give a single-cycle WAKE; WAKE_CYCLES=0 SHALL be rejected at elaboration.
REQ-019 wakeup and wfi_req rising in the same cycle in RUN SHALL keep RUN (wakeup wins).
REQ-020 The wake counter width SHALL be $clog2(WAKE_CYCLES+1); it SHALL NOT wrap.

Reset
REQ-021 While g_reset=1: state=RUN, clk_req all ones, sleeping=0, all counters 0; effective immediately, regardless of f_clk.
REQ-022 Reset asserted in any state, including mid-WAKE count or mid-DRAIN, SHALL return to these values; the first state after deassertion is RUN.

Configuration
REQ-023 Macro CORE_CLOCK_AUTO_GATE_EN defined: in RUN only, per-domain idle counter counts consecutive cycles of dom_busy[i]=0 and dom_req[i]=0; at IDLE_CYCLES, clk_req[i]=0 (registered) until dom_busy[i] or dom_req[i] =1, which re-asserts clk_req[i] combinationally in that same cycle and clears the counter; the counter saturates; leaving RUN clears all counters.
REQ-024 Macro not defined: no idle counters; clk_req all ones in RUN; no other behaviour changes.

Structure
REQ-025 The state enum (RUN, DRAIN, SLEEP, WAKE) SHALL live in shared package core_clock_pkg.
REQ-026 The per-domain saturating idle counter SHALL be sub-module core_clock_idle_ctr, instantiated N_DOMAINS times under the macro.

Verification (N_DOMAINS=3, WAKE_CYCLES=2, IDLE_CYCLES=8)
REQ-027 Reset pulse mid-WAKE -> clk_req=3'b111 and sleeping=0 immediately; RUN after release.
REQ-028 wfi_req=1, dom_busy=3'b010 for 4 cycles then 0 -> DRAIN for 5 cycles, then SLEEP; sleeping=1 and clk_req=3'b000.
REQ-029 In SLEEP, dom_req=3'b100 -> clk_req=3'b100 one cycle later; then wakeup=1 -> WAKE with clk_req=3'b111 for exactly 2 cycles, then RUN.
REQ-030 In DRAIN, wfi_req drops -> RUN next cycle and SLEEP is never entered; wfi_req and wakeup rise together in RUN -> state stays RUN.
REQ-031 With CORE_CLOCK_AUTO_GATE_EN, domain 1 idle 8 cycles -> clk_req[1]=0; dom_busy[1]=1 -> clk_req[1]=1 in the same cycle.
REQ-032 Without the macro, the same stimulus -> clk_req stays 3'b111 throughout RUN.
